// File: rtl/bpc_decomp_arb.sv
// Round-robin arbiter that funnels NCH compressed packet streams into one shared
// decompressor and tags each decompressed packet with the ID of the requester that sent it.
module bpc_decomp_arb #(
    parameter int NCH = 4,
    parameter int DW  = 64,
    parameter int IDQ = 2,
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    req_valid_i,
    input  logic [NCH*DW-1:0] req_data_i,
    input  logic [NCH-1:0]    req_sop_i,
    input  logic [NCH-1:0]    req_eop_i,
    output logic [NCH-1:0]    req_ready_o,
    output logic              dec_valid_o,
    output logic [DW-1:0]     dec_data_o,
    output logic              dec_sop_o,
    output logic              dec_eop_o,
    input  logic              dec_ready_i,
    input  logic              dec_valid_i,
    input  logic [DW-1:0]     dec_data_i,
    input  logic              dec_sop_i,
    input  logic              dec_eop_i,
    output logic              dec_ready_o,
    output logic              out_valid_o,
    output logic [DW-1:0]     out_data_o,
    output logic              out_sop_o,
    output logic              out_eop_o,
    output logic [IW-1:0]     out_id_o,
    input  logic              out_ready_i,
    output logic              busy_o,
    output logic              err_o
);
    // state   | meaning
    // S_IDLE  | no grant; pick next sop requester, drain stray beats
    // S_GRANT | channel gnt_q owns the decompressor input until its eop
    localparam int QAW = (IDQ > 1) ? $clog2(IDQ) : 1;
    localparam int CW  = $clog2(IDQ + 1);

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic            first_q, first_d;
    logic            err_q, err_d;
    logic [IW-1:0]   idq_q [IDQ];
    logic [QAW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;

    logic [NCH-1:0]  elig;
    logic            found;
    logic [IW-1:0]   sel;
    int              idx;
    logic            in_grant, q_full, q_empty;
    logic            g_valid, g_sop, g_eop;
    logic            hs, push, pop;
    logic            drain_err, sop_err, empty_err;

    assign in_grant = (state_q == S_GRANT);
    assign q_full   = (count_q == CW'(IDQ));
    assign q_empty  = (count_q == '0);
    assign g_valid  = req_valid_i[gnt_q];
    assign g_sop    = req_sop_i[gnt_q];
    assign g_eop    = req_eop_i[gnt_q];

    assign elig = req_valid_i & req_sop_i;

    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int i = 0; i < NCH; i++) begin
            idx = (int'(rr_ptr_q) + i) % NCH;
            if (!found && elig[idx]) begin
                found = 1'b1;
                sel   = IW'(idx);
            end
        end
    end

    assign dec_valid_o = in_grant & g_valid;
    assign dec_data_o  = req_data_i[int'(gnt_q)*DW +: DW];
    assign dec_sop_o   = in_grant & g_sop;
    assign dec_eop_o   = in_grant & g_eop;

    // Outside a grant, beats lacking sop are accepted and thrown away.
    always_comb begin
        req_ready_o = '0;
        if (in_grant) begin
            req_ready_o[gnt_q] = dec_ready_i;
        end else begin
            req_ready_o = req_valid_i & ~req_sop_i;
        end
    end

    assign hs        = in_grant & g_valid & dec_ready_i;
    assign push      = hs & g_sop & first_q;
    assign sop_err   = hs & g_sop & ~first_q;
    assign drain_err = ~in_grant & (|(req_valid_i & ~req_sop_i));

    assign out_valid_o = dec_valid_i & ~q_empty;
    assign dec_ready_o = out_ready_i & ~q_empty;
    assign out_data_o  = dec_data_i;
    assign out_sop_o   = dec_sop_i;
    assign out_eop_o   = dec_eop_i;
    assign out_id_o    = idq_q[rd_ptr_q];
    assign pop         = dec_valid_i & dec_ready_o & dec_eop_i;
    assign empty_err   = dec_valid_i & q_empty;

    assign busy_o = in_grant;
    assign err_o  = err_q;

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        rr_ptr_d = rr_ptr_q;
        first_d  = first_q;
        err_d    = drain_err | sop_err | empty_err;
        case (state_q)
            S_IDLE: begin
                // Gate on queue space here so a push in GRANT can never overflow.
                if (found && !q_full) begin
                    state_d  = S_GRANT;
                    gnt_d    = sel;
                    rr_ptr_d = IW'((int'(sel) + 1) % NCH);
                    first_d  = 1'b1;
                end
            end
            S_GRANT: begin
                if (hs) begin
                    first_d = 1'b0;
                    if (g_eop) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            gnt_q    <= '0;
            rr_ptr_q <= '0;
            first_q  <= 1'b0;
            err_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < IDQ; i++) idq_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
            first_q  <= first_d;
            err_q    <= err_d;
            count_q  <= count_d;
            if (push) begin
                idq_q[wr_ptr_q] <= gnt_q;
                wr_ptr_q <= (wr_ptr_q == QAW'(IDQ - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == QAW'(IDQ - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
        end
    end
endmodule
